// File: rtl/alu_seq16_if.sv
// alu_seq16_if: request/response and ALU command bus for the 16-bit ALU sequencer.
interface alu_seq16_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  op;
   logic [15:0] opA;
   logic [15:0] opB;
   logic [2:0]  amt;
   logic [2:0]  alu_cmd;
   logic [7:0]  alu_inA;
   logic [7:0]  alu_inB;
   logic        alu_imm;
   logic [4:0]  alu_last5bits;
   logic [7:0]  alu_rslt;
   logic        done;
   logic [15:0] result;
   logic        zero;
   logic        pari;
   modport slave (
      input  req_valid, op, opA, opB, amt, alu_rslt,
      output req_ready, alu_cmd, alu_inA, alu_inB, alu_imm, alu_last5bits, done, result, zero, pari
   );
   modport master (
      output req_valid, op, opA, opB, amt, alu_rslt,
      input  req_ready, alu_cmd, alu_inA, alu_inB, alu_imm, alu_last5bits, done, result, zero, pari
   );
endinterface

// File: rtl/alu_seq16.sv
// alu_seq16: drives an 8-bit ALU over two cycles (high byte, then low byte) to build 16-bit results.
module alu_seq16 #(
   parameter logic [2:0] IDLE_CMD = 3'b111
) (
   input logic       clk,
   input logic       reset,
   alu_seq16_if.slave bus
);
   typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;
   state_t      state_q;
   logic [1:0]  op_q;
   logic [15:0] a_q, b_q, result_q, result_d;
   logic [2:0]  amt_q;
   logic [7:0]  hi_q;
   logic        zero_q, pari_q, act, hi, shift;
   assign act = state_q == HI || state_q == LO;
   assign hi = state_q == HI;
   assign shift = ~op_q[1];
   assign result_d = {hi_q, bus.alu_rslt};
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q <= 2'b00;
         a_q <= 16'h0000;
         b_q <= 16'h0000;
         amt_q <= 3'd0;
         hi_q <= 8'h00;
         result_q <= 16'h0000;
         zero_q <= 1'b1;
         pari_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.req_valid) begin
               op_q <= bus.op;
               a_q <= bus.opA;
               b_q <= bus.opB;
               amt_q <= bus.amt;
               state_q <= HI;
            end
            HI: begin
               hi_q <= bus.alu_rslt;
               state_q <= LO;
            end
            LO: begin
               result_q <= result_d;
               zero_q <= result_d == 16'h0000;
               pari_q <= ^result_d;
               state_q <= DONE;
            end
            DONE: state_q <= IDLE;
         endcase
      end
   end
   assign bus.req_ready = state_q == IDLE;
   assign bus.done = state_q == DONE;
   assign bus.result = result_q;
   assign bus.zero = zero_q;
   assign bus.pari = pari_q;
   assign bus.alu_imm = 1'b0;
   // Shift ops funnel bytes through cmd 010; the LO half of SHL uses a plain left shift (001).
   assign bus.alu_cmd = !act ? IDLE_CMD
                      : !shift ? (op_q[0] ? 3'b100 : 3'b011)
                      : (hi || op_q[0]) ? 3'b010 : 3'b001;
   assign bus.alu_inA = !act ? 8'h00
                      : !shift ? (hi ? a_q[15:8] : a_q[7:0])
                      : (!hi && op_q[0]) ? a_q[15:8] : a_q[7:0];
   assign bus.alu_inB = !act ? 8'h00
                      : !shift ? (hi ? b_q[15:8] : b_q[7:0])
                      : hi ? a_q[15:8] : op_q[0] ? a_q[7:0] : 8'h00;
   assign bus.alu_last5bits = (act && shift) ? {amt_q, 2'b00} : 5'd0;
endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16: directed checks of alu_seq16 against a behavioural 8-bit ALU.
module tb_alu_seq16;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   alu_seq16_if bus ();
   alu_seq16 dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [2:0] cmd, input logic [7:0] a, input logic [7:0] b, input logic [4:0] l5);
      logic [7:0] t1, t2;
      int sh;
      sh = int'(l5[4:2]);
      t1 = b << sh;
      t2 = a >> (8 - sh);
      case (cmd)
         3'b001: alu_f = a << sh;
         3'b010: alu_f = t1 | t2;
         3'b011: alu_f = a ^ b;
         3'b100: alu_f = a & b;
         3'b111: alu_f = a;
         default: alu_f = 8'h00;
      endcase
   endfunction

   always_comb bus.alu_rslt = alu_f(bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_last5bits);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] n, input logic [15:0] exp, input logic [2:0] hi_cmd, input logic [4:0] hi_l5);
      int k;
      logic [2:0] c1;
      logic [4:0] l1;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.op = o;
      bus.opA = a;
      bus.opB = b;
      bus.amt = n;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.op = ~o;
      bus.opA = ~a;
      bus.opB = ~b;
      bus.amt = ~n;
      c1 = 3'd0;
      l1 = 5'd0;
      for (k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            c1 = bus.alu_cmd;
            l1 = bus.alu_last5bits;
         end
         if (bus.done) break;
      end
      chk({tag, "_latency"}, 32'(k), 32'd3);
      chk({tag, "_hicmd"}, 32'(c1), 32'(hi_cmd));
      chk({tag, "_hil5"}, 32'(l1), 32'(hi_l5));
      chk({tag, "_result"}, 32'(bus.result), 32'(exp));
      chk({tag, "_zero"}, 32'(bus.zero), 32'(exp == 16'h0000));
      chk({tag, "_pari"}, 32'(bus.pari), 32'(^exp));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, "_hold"}, 32'(bus.result), 32'(exp));
   endtask

   initial begin
      logic [15:0] res [2];
      int dcnt;
      bus.req_valid = 1'b0;
      bus.op = 2'b00;
      bus.opA = 16'h0000;
      bus.opB = 16'h0000;
      bus.amt = 3'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_result", 32'(bus.result), 32'h0);
      chk("rst_zero", 32'(bus.zero), 32'd1);
      chk("rst_pari", 32'(bus.pari), 32'd0);
      chk("rst_cmd", 32'(bus.alu_cmd), 32'h7);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_ins", 32'({bus.alu_inA, bus.alu_inB, bus.alu_last5bits, bus.alu_imm}), 32'h0);

      do_op("shl_1234_4", 2'b00, 16'h1234, 16'h0000, 3'd4, 16'h2340, 3'b010, 5'b10000);
      do_op("rol_8001_1", 2'b01, 16'h8001, 16'h0000, 3'd1, 16'h0003, 3'b010, 5'b00100);
      do_op("rol_beef_0", 2'b01, 16'hBEEF, 16'h0000, 3'd0, 16'hBEEF, 3'b010, 5'b00000);
      do_op("shl_beef_0", 2'b00, 16'hBEEF, 16'h0000, 3'd0, 16'hBEEF, 3'b010, 5'b00000);
      do_op("shl_8181_7", 2'b00, 16'h8181, 16'h0000, 3'd7, 16'hC080, 3'b010, 5'b11100);
      do_op("xor_ff00", 2'b10, 16'hFF00, 16'hFF00, 3'd3, 16'h0000, 3'b011, 5'b00000);
      do_op("xor_a5", 2'b10, 16'hA5A5, 16'h0FF0, 3'd3, 16'hAA55, 3'b011, 5'b00000);
      do_op("and_f0f0", 2'b11, 16'hF0F0, 16'h3C3C, 3'd0, 16'h3030, 3'b100, 5'b00000);
      do_op("and_0001", 2'b11, 16'h0001, 16'hFFFF, 3'd5, 16'h0001, 3'b100, 5'b00000);

      // Back-to-back with req_valid held: inputs switch to the second request right after the first accept.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.op = 2'b00;
      bus.opA = 16'h1234;
      bus.amt = 3'd4;
      @(posedge clk);
      #1;
      bus.op = 2'b01;
      bus.opA = 16'h8001;
      bus.amt = 3'd1;
      dcnt = 0;
      res[0] = 16'h0;
      res[1] = 16'h0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk($sformatf("b2b_ready_%0d", k), 32'(bus.req_ready), 32'(k == 4 || k == 8));
         chk($sformatf("b2b_done_%0d", k), 32'(bus.done), 32'(k == 3 || k == 7));
         if (bus.done && dcnt < 2) begin
            res[dcnt] = bus.result;
            dcnt++;
         end
      end
      bus.req_valid = 1'b0;
      chk("b2b_res0", 32'(res[0]), 32'h2340);
      chk("b2b_res1", 32'(res[1]), 32'h0003);
      repeat (4) @(negedge clk);

      // Reset during LO aborts the op.
      bus.req_valid = 1'b1;
      bus.op = 2'b00;
      bus.opA = 16'hFFFF;
      bus.amt = 3'd2;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_in_lo", 32'(bus.alu_cmd), 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_result", 32'(bus.result), 32'h0);
      chk("abort_zero", 32'(bus.zero), 32'd1);
      dcnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.done) dcnt++;
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);
      do_op("post_abort", 2'b00, 16'h00FF, 16'h0000, 3'd2, 16'h03FC, 3'b010, 5'b01000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
